alu_writeback: RTL and testbench
================================

ALU_WRITEBACK -- requirements
Module: alu_writeback

Interface
REQ-001 Parameter: N, default 16, datapath width.
REQ-002 Parameter: RADDR, default 4, register-file address width.
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port: in_valid  input  1  ALU result presented this cycle.
REQ-006 Port: in_ready  output  1  block can accept a result.
REQ-007 Port: y / yhigh / out_to_a  input  N each  ALU low result / high result (32-bit ops) / multiply high half.
REQ-008 Port: co, zero, overflow, negative  input  1 each  ALU flags.
REQ-009 Port: use32bit  input  1  yhigh is to be written.
REQ-010 Port: a_wr_en  input  1  out_to_a is to be written to register 0 (A).
REQ-011 Port: flags_we  input  1  op updates flags.
REQ-012 Port: dest  input  RADDR  destination register for y.
REQ-013 Port: rf_we  output  1  register-file write request.
REQ-014 Port: rf_addr  output  RADDR  write address.
REQ-015 Port: rf_data  output  N  write data.
REQ-016 Port: rf_ready  input  1  register file accepts the write this cycle.
REQ-017 Port: flags  output  4  registered {C,Z,V,N}.
REQ-018 Port: op_done  output  1  final write of an op accepted this cycle.

Function
REQ-019 States SHALL be IDLE, WR_LO, WR_HI, WR_A.
REQ-020 in_ready SHALL be 1 only in IDLE.
REQ-021 Accept = in_valid & in_ready at a rising edge: capture y, yhigh, out_to_a, use32bit, a_wr_en, dest; go IDLE->WR_LO.
REQ-022 On accept with flags_we=1, flags SHALL load {co,zero,overflow,negative} at the same edge; flags_we=0 leaves flags unchanged.
REQ-023 In WR_LO: rf_we=1, rf_addr=dest_q, rf_data=y_q.
REQ-024 In WR_HI: rf_we=1, rf_addr=(dest_q+1) mod 2^RADDR (wraps 15->0), rf_data=yhigh_q.
REQ-025 In WR_A: rf_we=1, rf_addr=0, rf_data=out_to_a_q.
REQ-026 In IDLE: rf_we=0, rf_addr=0, rf_data=0.
REQ-027 A write state SHALL advance only at an edge with rf_ready=1; with rf_ready=0, state and all rf_* outputs hold unchanged (no limit on stall length).
REQ-028 Transitions on accepted write: WR_LO->WR_HI if use32bit_q, else WR_A if a_wr_en_q, else IDLE; WR_HI->WR_A if a_wr_en_q, else IDLE; WR_A->IDLE.
REQ-029 Both use32bit and a_wr_en set: three writes in order lo, hi, A; A write last wins if dest_q or dest_q+1 equals 0.
REQ-030 op_done SHALL be combinational: rf_we & rf_ready & (next state is IDLE).
REQ-031 Latency: minimum 1 write cycle after accept (1, 2 or 3 writes); back-to-back throughput one op per (writes+1) cycles.
REQ-032 in_valid while not IDLE SHALL be ignored; upstream holds result until in_ready.
REQ-033 rf_ready while rf_we=0 SHALL have no effect.

Reset
REQ-034 rst_n=0 at a rising edge SHALL force state IDLE, flags=4'b0000, all captured registers 0, regardless of state.
REQ-035 Reset mid-op SHALL discard remaining writes; rf_we=0 and op_done=0 from the cycle after the reset edge.
REQ-036 in_ready SHALL be 1 the first cycle after rst_n returns high.

Verification
REQ-037 16-bit add: y=0x1234, dest=3, flags_we=1, co=1, rf_ready=1 -> one cycle rf_we, addr 3, data 0x1234, op_done=1; flags=4'b1000; in_ready back next cycle.
REQ-038 32-bit op: y=0xBEEF, yhigh=0xDEAD, dest=15 -> writes (15,0xBEEF) then (0,0xDEAD); op_done only on second.
REQ-039 Multiply: y=0x0002, out_to_a=0xFFFF, a_wr_en=1, use32bit=1, dest=5 -> writes (5,0x0002),(6,yhigh),(0,0xFFFF) in 3 consecutive cycles.
REQ-040 Stall: rf_ready=0 for 4 cycles in WR_LO -> rf_we, rf_addr, rf_data stable, in_ready=0, no op_done; completes on first rf_ready=1.
REQ-041 Reset during WR_HI -> next cycle rf_we=0, flags=0, in_ready=1; the high write never occurs.
REQ-042 flags_we=0 op after flags=4'b0101 -> flags remain 4'b0101 through and after the op.

Source files
------------

// File: rtl/alu_writeback.sv
// rtl/alu_writeback.sv - ALU result writeback sequencer: up to three register-file writes per op plus flag register.
module alu_writeback #(
  parameter int N     = 16,
  parameter int RADDR = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     y,
  input  logic [N-1:0]     yhigh,
  input  logic [N-1:0]     out_to_a,
  input  logic             co,
  input  logic             zero,
  input  logic             overflow,
  input  logic             negative,
  input  logic             use32bit,
  input  logic             a_wr_en,
  input  logic             flags_we,
  input  logic [RADDR-1:0] dest,
  output logic             rf_we,
  output logic [RADDR-1:0] rf_addr,
  output logic [N-1:0]     rf_data,
  input  logic             rf_ready,
  output logic [3:0]       flags,
  output logic             op_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_LO = 2'd1,
    WR_HI = 2'd2,
    WR_A  = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [N-1:0]     y_q, yhigh_q, a_q;
  logic             use32_q, awr_q;
  logic [RADDR-1:0] dest_q;
  logic             accept;

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      y_q     <= '0;
      yhigh_q <= '0;
      a_q     <= '0;
      use32_q <= 1'b0;
      awr_q   <= 1'b0;
      dest_q  <= '0;
      flags   <= 4'b0000;
    end else begin
      state <= state_n;
      if (accept) begin
        y_q     <= y;
        yhigh_q <= yhigh;
        a_q     <= out_to_a;
        use32_q <= use32bit;
        awr_q   <= a_wr_en;
        dest_q  <= dest;
        if (flags_we)
          flags <= {co, zero, overflow, negative};
      end
    end
  end

  // Write states only advance when the register file takes the write.
  always_comb begin
    state_n  = state;
    in_ready = 1'b0;
    rf_we    = 1'b0;
    rf_addr  = '0;
    rf_data  = '0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid)
          state_n = WR_LO;
      end
      WR_LO: begin
        rf_we   = 1'b1;
        rf_addr = dest_q;
        rf_data = y_q;
        if (rf_ready) begin
          if (use32_q)
            state_n = WR_HI;
          else if (awr_q)
            state_n = WR_A;
          else
            state_n = IDLE;
        end
      end
      WR_HI: begin
        rf_we   = 1'b1;
        rf_addr = dest_q + RADDR'(1);
        rf_data = yhigh_q;
        if (rf_ready)
          state_n = awr_q ? WR_A : IDLE;
      end
      WR_A: begin
        rf_we   = 1'b1;
        rf_addr = '0;
        rf_data = a_q;
        if (rf_ready)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign op_done = rf_we & rf_ready & (state_n == IDLE);

endmodule

// File: tb/tb_alu_writeback.sv
// tb/tb_alu_writeback.sv - directed scoreboard bench for alu_writeback.
module tb_alu_writeback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] y, yhigh, out_to_a;
  logic        co, zero, overflow, negative;
  logic        use32bit, a_wr_en, flags_we;
  logic [3:0]  dest;
  logic        rf_we;
  logic [3:0]  rf_addr;
  logic [15:0] rf_data;
  logic        rf_ready;
  logic [3:0]  flags;
  logic        op_done;

  typedef struct {
    logic [3:0]  addr;
    logic [15:0] data;
    logic        last;
  } wr_t;

  wr_t exp_q[$];
  int  vectors     = 0;
  int  miscompares = 0;
  int  ncyc;

  alu_writeback #(.N(16), .RADDR(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .y(y), .yhigh(yhigh), .out_to_a(out_to_a),
    .co(co), .zero(zero), .overflow(overflow), .negative(negative),
    .use32bit(use32bit), .a_wr_en(a_wr_en), .flags_we(flags_we), .dest(dest),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data), .rf_ready(rf_ready),
    .flags(flags), .op_done(op_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] a, input logic [15:0] d, input logic l);
    wr_t e;
    e.addr = a; e.data = d; e.last = l;
    exp_q.push_back(e);
  endtask

  // Present one op for a single edge; caller is at posedge+1.
  task automatic send(input logic [15:0] yv, input logic [15:0] yh, input logic [15:0] av,
                      input logic u32, input logic awr, input logic fwe,
                      input logic [3:0] flg, input logic [3:0] d);
    in_valid = 1'b1; y = yv; yhigh = yh; out_to_a = av;
    use32bit = u32; a_wr_en = awr; flags_we = fwe; dest = d;
    {co, zero, overflow, negative} = flg;
    @(posedge clk); #1;
    in_valid = 1'b0; flags_we = 1'b0;
  endtask

  task automatic drain(input int budget, output int cycles);
    wr_t e;
    cycles = 0;
    while (exp_q.size() > 0 && cycles < budget) begin
      @(negedge clk);
      if (rf_we && rf_ready) begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(rf_addr), 32'(e.addr));
        check("wr_data", 32'(rf_data), 32'(e.data));
        check("wr_op_done", 32'(op_done), 32'(e.last));
      end
      @(posedge clk); #1;
      cycles++;
    end
    if (exp_q.size() > 0) begin
      check("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; rf_ready = 1'b1;
    y = '0; yhigh = '0; out_to_a = '0;
    {co, zero, overflow, negative} = 4'b0000;
    use32bit = 1'b0; a_wr_en = 1'b0; flags_we = 1'b0; dest = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_rf_we", 32'(rf_we), 32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    check("rst_op_done", 32'(op_done), 32'd0);

    // 16-bit add with carry
    push(4'd3, 16'h1234, 1'b1);
    send(16'h1234, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 4'b1000, 4'd3);
    check("add_flags", 32'(flags), 32'b1000);
    check("add_in_ready_busy", 32'(in_ready), 32'd0);
    drain(10, ncyc);
    check("add_cycles", 32'(ncyc), 32'd1);
    check("add_in_ready_back", 32'(in_ready), 32'd1);

    // 32-bit op with destination wrap 15 -> 0
    push(4'd15, 16'hBEEF, 1'b0);
    push(4'd0, 16'hDEAD, 1'b1);
    send(16'hBEEF, 16'hDEAD, 16'h0, 1'b1, 1'b0, 1'b0, 4'b1111, 4'd15);
    drain(10, ncyc);
    check("w32_cycles", 32'(ncyc), 32'd2);
    check("w32_flags_kept", 32'(flags), 32'b1000);

    // multiply: lo, hi, A back to back
    push(4'd5, 16'h0002, 1'b0);
    push(4'd6, 16'h1357, 1'b0);
    push(4'd0, 16'hFFFF, 1'b1);
    send(16'h0002, 16'h1357, 16'hFFFF, 1'b1, 1'b1, 1'b0, 4'b0000, 4'd5);
    drain(10, ncyc);
    check("mul_cycles", 32'(ncyc), 32'd3);

    // A-only write after low write
    push(4'd9, 16'h0042, 1'b0);
    push(4'd0, 16'h7777, 1'b1);
    send(16'h0042, 16'h0, 16'h7777, 1'b0, 1'b1, 1'b0, 4'b0000, 4'd9);
    drain(10, ncyc);
    check("awr_cycles", 32'(ncyc), 32'd2);

    // stall in WR_LO for 4 cycles with a competing in_valid that must be ignored
    rf_ready = 1'b0;
    send(16'hA5A5, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'd7);
    in_valid = 1'b1; y = 16'h9999; dest = 4'd1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_we", 32'(rf_we), 32'd1);
      check("stall_addr", 32'(rf_addr), 32'd7);
      check("stall_data", 32'(rf_data), 32'hA5A5);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_op_done", 32'(op_done), 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rf_ready = 1'b1;
    push(4'd7, 16'hA5A5, 1'b1);
    drain(10, ncyc);
    check("stall_done_cycles", 32'(ncyc), 32'd1);
    @(negedge clk);
    check("no_ghost_op", 32'(rf_we), 32'd0);
    @(posedge clk); #1;

    // flags load then held across a flags_we=0 op
    push(4'd2, 16'h0000, 1'b1);
    send(16'h0000, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 4'b0101, 4'd2);
    check("flags_load", 32'(flags), 32'b0101);
    drain(10, ncyc);
    push(4'd4, 16'h8001, 1'b1);
    send(16'h8001, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 4'b1010, 4'd4);
    check("flags_hold_during", 32'(flags), 32'b0101);
    drain(10, ncyc);
    check("flags_hold_after", 32'(flags), 32'b0101);

    // reset in WR_HI drops the high write
    push(4'd2, 16'h1111, 1'b0);
    send(16'h1111, 16'h2222, 16'h0, 1'b1, 1'b0, 1'b1, 4'b0011, 4'd2);
    drain(10, ncyc);
    check("pre_rst_in_hi", 32'({rf_we, rf_addr}), 32'({1'b1, 4'd3}));
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst_rf_we", 32'(rf_we), 32'd0);
    check("midrst_op_done", 32'(op_done), 32'd0);
    check("midrst_flags", 32'(flags), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_no_write", 32'(rf_we), 32'd0);
      @(posedge clk); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
